// File: rtl/ravenoc_edge_sink_pkg.sv
// Shared types and constants for the RaveNoC edge-port terminator.
package ravenoc_edge_sink_pkg;

    localparam int EDGE_CNT_WIDTH = 16;

    typedef enum logic {
        EDGE_BLOCK = 1'b0,
        EDGE_SINK  = 1'b1
    } edge_mode_t;

    typedef enum logic {
        EDGE_IDLE   = 1'b0,
        EDGE_IN_PKT = 1'b1
    } edge_vc_state_t;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10,
        RSVD_FLIT = 2'b11
    } flit_type_t;

    // A single-VC link still needs a one-bit VC id port
    function automatic int vc_id_width(input int n_vc);
        return (n_vc > 1) ? $clog2(n_vc) : 1;
    endfunction

endpackage

// File: rtl/ravenoc_edge_sink_vc_tracker.sv
// Per-VC packet framing tracker: follows HEAD/BODY/TAIL framing and flags
// newly seen packets and framing errors as single-cycle strobes.
module ravenoc_edge_vc_tracker
    import ravenoc_edge_sink_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flit_valid,
    input  flit_type_t flit_type,
    output logic       pkt_inc,
    output logic       err_inc
);

    edge_vc_state_t state_r;

    // Strobes depend on the current state so the top can count in the accept cycle
    always_comb begin
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        if (flit_valid) begin
            case (flit_type)
                HEAD_FLIT: begin
                    pkt_inc = 1'b1;
                    err_inc = (state_r == EDGE_IN_PKT);
                end
                BODY_FLIT: err_inc = (state_r == EDGE_IDLE);
                TAIL_FLIT: err_inc = (state_r == EDGE_IDLE);
                RSVD_FLIT: err_inc = 1'b1;
                default:   err_inc = 1'b1;
            endcase
        end else begin
            pkt_inc = 1'b0;
            err_inc = 1'b0;
        end
    end

    // Framing FSM; BODY and reserved types never change state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EDGE_IDLE;
        end else if (flit_valid) begin
            case (flit_type)
                HEAD_FLIT: state_r <= EDGE_IN_PKT;
                TAIL_FLIT: state_r <= EDGE_IDLE;
                BODY_FLIT: state_r <= state_r;
                RSVD_FLIT: state_r <= state_r;
                default:   state_r <= state_r;
            endcase
        end
    end

endmodule

// File: rtl/ravenoc_edge_sink.sv
// Edge-port terminator for unused mesh boundary links (BLOCK or SINK mode).
// Optional first-error capture is built when RAVENOC_EDGE_CAPTURE_EN is defined.
module ravenoc_edge_sink
    import ravenoc_edge_sink_pkg::*;
#(
    parameter int         FLIT_WIDTH = 34,
    parameter int         N_VIRT_CHN = 3,
    parameter int         CNT_WIDTH  = EDGE_CNT_WIDTH,
    parameter edge_mode_t MODE       = EDGE_SINK,
    localparam int        VC_W       = vc_id_width(N_VIRT_CHN)
) (
    input  logic                  clk_noc,
    input  logic                  arst_noc,
    input  logic                  recv_valid,
    input  logic [VC_W-1:0]       recv_vc_id,
    input  logic [FLIT_WIDTH-1:0] recv_flit,
    output logic [N_VIRT_CHN-1:0] recv_ready,
    output logic                  send_valid,
    output logic [FLIT_WIDTH-1:0] send_flit,
    input  logic                  clr_i,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  irq_o,
    output logic                  cap_vld_o,
    output logic [FLIT_WIDTH-1:0] cap_flit_o,
    output logic [VC_W-1:0]       cap_vc_o
);

    logic [N_VIRT_CHN-1:0] ready_r;
    logic [CNT_WIDTH-1:0]  pkt_cnt_r;
    logic [CNT_WIDTH-1:0]  err_cnt_r;
    logic [CNT_WIDTH-1:0]  pkt_nxt_s;
    logic [CNT_WIDTH-1:0]  err_nxt_s;
    logic                  irq_r;
    logic                  accept_s;
    logic                  in_range_s;
    logic                  pkt_ev_s;
    logic                  err_ev_s;
    logic [N_VIRT_CHN-1:0] vc_hit_s;
    logic [N_VIRT_CHN-1:0] pkt_inc_s;
    logic [N_VIRT_CHN-1:0] err_inc_s;
    flit_type_t            type_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Ready comes up one clock after reset release and only in SINK mode
    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            ready_r <= {N_VIRT_CHN{1'b0}};
        end else begin
            ready_r <= (MODE == EDGE_SINK) ? {N_VIRT_CHN{1'b1}} : {N_VIRT_CHN{1'b0}};
        end
    end

    assign recv_ready = ready_r;
    assign send_valid = 1'b0;
    assign send_flit  = {FLIT_WIDTH{1'b0}};

    // All ready bits move together, so bit 0 also covers out-of-range VC ids
    assign accept_s   = recv_valid && ready_r[0];
    assign in_range_s = ({1'b0, recv_vc_id} < (VC_W + 1)'(N_VIRT_CHN));
    assign type_s     = flit_type_t'(recv_flit[FLIT_WIDTH-1 -: 2]);

    for (genvar i = 0; i < N_VIRT_CHN; i++) begin : g_vc
        assign vc_hit_s[i] = accept_s && in_range_s && (recv_vc_id == VC_W'(i));

        ravenoc_edge_vc_tracker u_tracker (
            .clk        (clk_noc),
            .rst        (arst_noc),
            .flit_valid (vc_hit_s[i]),
            .flit_type  (type_s),
            .pkt_inc    (pkt_inc_s[i]),
            .err_inc    (err_inc_s[i])
        );
    end

    assign pkt_ev_s = |pkt_inc_s;
    assign err_ev_s = (|err_inc_s) || (accept_s && !in_range_s);

    // Counter next-state: an event in the clear cycle still counts once
    always_comb begin
        pkt_nxt_s = pkt_cnt_r;
        err_nxt_s = err_cnt_r;
        if (clr_i) begin
            pkt_nxt_s = pkt_ev_s ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
            err_nxt_s = err_ev_s ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
        end else begin
            pkt_nxt_s = pkt_ev_s ? sat_inc(pkt_cnt_r) : pkt_cnt_r;
            err_nxt_s = err_ev_s ? sat_inc(err_cnt_r) : err_cnt_r;
        end
    end

    // Counters and sticky misroute interrupt
    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            pkt_cnt_r <= {CNT_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            pkt_cnt_r <= pkt_nxt_s;
            err_cnt_r <= err_nxt_s;
            if (accept_s) begin
                irq_r <= 1'b1;
            end else if (clr_i) begin
                irq_r <= 1'b0;
            end
        end
    end

    assign pkt_cnt_o = pkt_cnt_r;
    assign err_cnt_o = err_cnt_r;
    assign irq_o     = irq_r;

`ifdef RAVENOC_EDGE_CAPTURE_EN
    logic                  cap_vld_r;
    logic [FLIT_WIDTH-1:0] cap_flit_r;
    logic [VC_W-1:0]       cap_vc_r;

    // First error after reset/clear is latched; a clear opens the window again
    always_ff @(posedge clk_noc or posedge arst_noc) begin
        if (arst_noc) begin
            cap_vld_r  <= 1'b0;
            cap_flit_r <= {FLIT_WIDTH{1'b0}};
            cap_vc_r   <= {VC_W{1'b0}};
        end else if (err_ev_s && (!cap_vld_r || clr_i)) begin
            cap_vld_r  <= 1'b1;
            cap_flit_r <= recv_flit;
            cap_vc_r   <= recv_vc_id;
        end else if (clr_i) begin
            cap_vld_r  <= 1'b0;
        end
    end

    assign cap_vld_o  = cap_vld_r;
    assign cap_flit_o = cap_flit_r;
    assign cap_vc_o   = cap_vc_r;
`else
    logic unused_payload_s;

    assign unused_payload_s = ^recv_flit[FLIT_WIDTH-3:0];
    assign cap_vld_o  = 1'b0;
    assign cap_flit_o = {FLIT_WIDTH{1'b0}};
    assign cap_vc_o   = {VC_W{1'b0}};
`endif

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
// Bench for ravenoc_edge_sink: a SINK instance, a 4-bit-counter SINK instance and
// a BLOCK instance share one stimulus stream; a scoreboard queue holds expectations.
module tb_ravenoc_edge_sink;
    import ravenoc_edge_sink_pkg::*;

    localparam int FW = 34;
    localparam int NV = 3;
    localparam int VW = 2;

    typedef struct {
        int          pkt;
        int          err;
        bit          irq;
        bit          cap_v;
        logic [FW-1:0] cap_f;
        logic [VW-1:0] cap_vc;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          valid = 1'b0;
    logic [VW-1:0] vc = '0;
    logic [FW-1:0] flit = '0;
    logic          clr = 1'b0;

    logic [NV-1:0] ready_a, ready_b, ready_c;
    logic          sv_a, sv_b, sv_c;
    logic [FW-1:0] sf_a, sf_b, sf_c;
    logic [15:0]   pkt_a, err_a, pkt_c, err_c;
    logic [3:0]    pkt_b, err_b;
    logic          irq_a, irq_b, irq_c;
    logic          cv_a, cv_b, cv_c;
    logic [FW-1:0] cf_a, cf_b, cf_c;
    logic [VW-1:0] cvc_a, cvc_b, cvc_c;

    int n_checks = 0;
    int n_err = 0;

    exp_t sb_q[$];
    int   m_state[NV];
    int   m_pkt, m_err;
    bit   m_irq, m_ready, m_cap_v;
    logic [FW-1:0] m_cap_f;
    logic [VW-1:0] m_cap_vc;

    always #5 clk = ~clk;

    ravenoc_edge_sink #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .CNT_WIDTH(16), .MODE(EDGE_SINK)) dut_a (
        .clk_noc(clk), .arst_noc(arst), .recv_valid(valid), .recv_vc_id(vc), .recv_flit(flit),
        .recv_ready(ready_a), .send_valid(sv_a), .send_flit(sf_a), .clr_i(clr),
        .pkt_cnt_o(pkt_a), .err_cnt_o(err_a), .irq_o(irq_a),
        .cap_vld_o(cv_a), .cap_flit_o(cf_a), .cap_vc_o(cvc_a));

    ravenoc_edge_sink #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .CNT_WIDTH(4), .MODE(EDGE_SINK)) dut_b (
        .clk_noc(clk), .arst_noc(arst), .recv_valid(valid), .recv_vc_id(vc), .recv_flit(flit),
        .recv_ready(ready_b), .send_valid(sv_b), .send_flit(sf_b), .clr_i(clr),
        .pkt_cnt_o(pkt_b), .err_cnt_o(err_b), .irq_o(irq_b),
        .cap_vld_o(cv_b), .cap_flit_o(cf_b), .cap_vc_o(cvc_b));

    ravenoc_edge_sink #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .CNT_WIDTH(16), .MODE(EDGE_BLOCK)) dut_c (
        .clk_noc(clk), .arst_noc(arst), .recv_valid(valid), .recv_vc_id(vc), .recv_flit(flit),
        .recv_ready(ready_c), .send_valid(sv_c), .send_flit(sf_c), .clr_i(clr),
        .pkt_cnt_o(pkt_c), .err_cnt_o(err_c), .irq_o(irq_c),
        .cap_vld_o(cv_c), .cap_flit_o(cf_c), .cap_vc_o(cvc_c));

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_state[i] = 0;
        m_pkt = 0; m_err = 0; m_irq = 0; m_ready = 0;
        m_cap_v = 0; m_cap_f = '0; m_cap_vc = '0;
    endtask

    // Every output must read zero while reset is held
    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {ready_a, ready_b, ready_c}, 64'd0);
        chk({tag, "_cnt"}, {pkt_a, err_a, pkt_b, err_b, pkt_c, err_c}, 64'd0);
        chk({tag, "_irq_cap"}, {irq_a, irq_b, irq_c, cv_a, cv_b, cv_c}, 64'd0);
        chk({tag, "_send"}, {sv_a, sv_b, sv_c, |sf_a, |sf_b, |sf_c}, 64'd0);
    endtask

    // One clock of stimulus: drive, predict, push; then pop and compare after the edge
    task automatic step(input logic v, input logic [VW-1:0] id, input logic [1:0] ty, input logic c);
        exp_t e;
        bit acc, pi, ei;
        logic [FW-1:0] f;
        @(negedge clk);
        f = {ty, $urandom()};
        valid = v; vc = id; flit = f; clr = c;
        acc = v && m_ready;
        pi = 0; ei = 0;
        if (acc) begin
            if (int'(id) >= NV) begin
                ei = 1;
            end else begin
                case (ty)
                    2'b00: begin pi = 1; ei = (m_state[id] == 1); m_state[id] = 1; end
                    2'b01: ei = (m_state[id] == 0);
                    2'b10: begin ei = (m_state[id] == 0); m_state[id] = 0; end
                    default: ei = 1;
                endcase
            end
        end
        m_pkt = c ? int'(pi) : m_pkt + int'(pi);
        m_err = c ? int'(ei) : m_err + int'(ei);
        if (acc) m_irq = 1;
        else if (c) m_irq = 0;
        if (ei && (!m_cap_v || c)) begin
            m_cap_v = 1; m_cap_f = f; m_cap_vc = id;
        end else if (c) begin
            m_cap_v = 0;
        end
        m_ready = 1;
        e.pkt = m_pkt; e.err = m_err; e.irq = m_irq;
        e.cap_v = m_cap_v; e.cap_f = m_cap_f; e.cap_vc = m_cap_vc;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        valid = 1'b0; clr = 1'b0;
        e = sb_q.pop_front();
        chk("a_pkt", pkt_a, e.pkt);
        chk("a_err", err_a, e.err);
        chk("a_irq", irq_a, e.irq);
        chk("a_ready", ready_a, m_ready ? 3'b111 : 3'b000);
        chk("b_pkt", pkt_b, sat(e.pkt, 15));
        chk("b_err", err_b, sat(e.err, 15));
        chk("b_irq", irq_b, e.irq);
        chk("c_ready", ready_c, 3'b000);
        chk("c_state", {pkt_c, err_c, irq_c}, 64'd0);
`ifdef RAVENOC_EDGE_CAPTURE_EN
        chk("a_cap_vld", cv_a, e.cap_v);
        chk("b_cap_vld", cv_b, e.cap_v);
        if (e.cap_v) begin
            chk("a_cap_flit", cf_a, e.cap_f);
            chk("a_cap_vc", cvc_a, e.cap_vc);
        end
`else
        chk("a_cap_tied", {cv_a, cf_a, cvc_a}, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        arst = 1'b0;
        step(1'b0, 2'd0, 2'b00, 1'b0);              // ready rises

        step(1'b1, 2'd0, 2'b00, 1'b0);              // VC0 HEAD
        step(1'b1, 2'd0, 2'b01, 1'b0);              // VC0 BODY
        step(1'b1, 2'd0, 2'b10, 1'b0);              // VC0 TAIL

        step(1'b1, 2'd1, 2'b01, 1'b0);              // VC1 lone BODY
        step(1'b1, 2'd2, 2'b00, 1'b0);              // VC2 HEAD
        step(1'b1, 2'd2, 2'b00, 1'b0);              // VC2 truncating HEAD
        step(1'b1, 2'd2, 2'b10, 1'b0);              // VC2 TAIL
        step(1'b1, 2'd2, 2'b01, 1'b0);              // VC2 BODY: IDLE error

        step(1'b0, 2'd0, 2'b00, 1'b1);              // clear only
        step(1'b1, 2'd3, 2'b00, 1'b0);              // out-of-range VC
        step(1'b1, 2'd0, 2'b11, 1'b1);              // clear + reserved type
        step(1'b0, 2'd0, 2'b00, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'(i % NV), 2'b00, 1'b0);
            step(1'b1, 2'(i % NV), 2'b10, 1'b0);
        end
        step(1'b1, 2'd0, 2'b00, 1'b1);              // clear + HEAD
        step(1'b1, 2'd0, 2'b10, 1'b0);

        step(1'b1, 2'd0, 2'b00, 1'b0);              // VC0 into IN_PKT
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        step(1'b0, 2'd0, 2'b00, 1'b0);
        step(1'b1, 2'd0, 2'b01, 1'b0);              // BODY on VC0 after reset

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
